mem_load_sequencer: RTL and testbench
=====================================

# mem_load_sequencer

Parametrised successor to the chip-level weight/image loader. It streams `NUM_CH` logical channels (default: CNN weights, FC weights, image) from the IO block into `NUM_RAM` on-chip memories in strict channel order. Each channel has its own runtime word count, base address and destination RAM, and the block runs a start/busy/done handshake with checked end-of-channel framing. It sits between `io` and the CNN/FC memories, replacing free-running index loops with a single registered write path.

## Interface
- `DATA_W`, 16, word width
- `ADDR_W`, 16, RAM address width
- `CNT_W`, 16, per-channel word-count width
- `NUM_CH`, 3, number of load channels, serviced 0..NUM_CH-1
- `NUM_RAM`, 2, number of destination memories
- `RSEL_W`, `$clog2(NUM_RAM)` (min 1), RAM select width

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a load sequence; sampled only in IDLE
- `ch_count`  in  NUM_CH*CNT_W  words per channel; channel i at `[i*CNT_W +: CNT_W]`
- `ch_base`  in  NUM_CH*ADDR_W  first write address per channel
- `ch_ram`  in  NUM_CH*RSEL_W  destination RAM index per channel
- `ch_req`  out  NUM_CH  one-hot request telling `io` which channel to stream
- `s_valid`  in  1  source word valid
- `s_data`  in  DATA_W  source word
- `s_last`  in  1  final word of the current channel
- `s_ready`  out  1  sequencer accepts word
- `ram_we`  out  NUM_RAM  one-hot write enable
- `ram_addr`  out  ADDR_W  shared write address
- `ram_wdata`  out  DATA_W  shared write data
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle pulse at sequence end
- `err`  out  NUM_CH  sticky per-channel framing/overflow error, cleared on accepted `start`

## Operation
- FSM states: IDLE, SETUP, XFER, NEXT, DONE.
- IDLE: on `start`, latch the `ch_count`, `ch_base` and `ch_ram` vectors into shadow registers, clear `err`, set ch=0, go to SETUP. Config changes after this have no effect until the next start.
- SETUP: if count[ch]==0, go to NEXT and issue no writes. Otherwise load addr=base[ch] and remaining=count[ch]. If base+count > 2^ADDR_W, set `err[ch]` and go to NEXT. Otherwise go to XFER.
- XFER:
  - `ch_req[ch]`=1.
  - `s_ready`=1.
  - On each handshake (`s_valid & s_ready`), register a write: addr++, remaining--.
  - Framing rule 1: `s_last` with remaining>1 sets `err[ch]` and terminates the channel (go to NEXT).
  - Framing rule 2: the final counted beat without `s_last` sets `err[ch]`; the channel still ends (go to NEXT).
- NEXT: ch++. If ch==NUM_CH go to DONE, else go to SETUP.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` while `busy` is ignored.
- Address arithmetic is ADDR_W unsigned. Count is compared full-width; no wrap is permitted, because overflow is rejected in SETUP.
- Channels may share a RAM at disjoint bases (image appended after CNN weights).

## Timing
- Reset values:
  - state=IDLE
  - `ch_req`=0, `s_ready`=0
  - `ram_we`=0, `ram_addr`=0, `ram_wdata`=0
  - `busy`=0, `done`=0
  - `err`=0
- `rst` asserted mid-sequence aborts on the next edge. No further writes occur.
- Write latency: a handshake at cycle N gives `ram_we[ch_ram]`, `ram_addr` and `ram_wdata` valid at N+1 for exactly one cycle.
- Throughput: one word per cycle in XFER. `s_valid` may deassert at any time without loss.
- `s_ready` is registered and derived only from state. It drops the cycle after the final/terminating handshake; no combinational path from `s_valid`.
- Per-channel overhead: SETUP + NEXT = 2 idle cycles.
- `busy`=1 from the cycle after an accepted `start` through the DONE cycle inclusive.
- Sequence latency = 1 + Σ(count[i] + 2) + stall cycles.

## Structure
- Package `loader_pkg`:
  - state enum `ld_state_t`
  - default channel indices: `CH_CNN`=0, `CH_FC`=1, `CH_IMG`=2
  - RAM indices: `RAM_CNN`=0, `RAM_FC`=1
  - default counts: 50704, 11218, 1024
  - default image base 50704
- One natural sub-module, `ld_chan_ctr`: loadable address/remaining counter with last-beat and overflow flags. The FSM and write register stay in the top level.

## Test plan
- Counts {4,3,2}, bases {0,0,8}, RAMs {0,1,0}, continuous `s_valid` with correct `s_last` -> 9 writes: RAM0 addr 0-3, RAM1 addr 0-2, RAM0 addr 8-9; `done` one pulse at cycle 1+15; `err`=0.
- Counts {3,0,2} -> channel 1 skipped; `ch_req` never 3'b010; 5 writes total.
- `s_valid` toggled every other cycle, count 4 -> 4 writes in order, data unchanged, no duplicates.
- `s_last` on beat 2 of count 4 -> `err`=3'b001, 2 writes on ch0, sequencer proceeds to ch1. Separately, no `s_last` on final beat -> `err[ch]` set, all count writes made.
- Base 16'hFFFE with count 3 -> `err[ch]`=1, zero writes for that channel; other channels unaffected.
- `rst` during ch1 XFER -> next cycle all outputs at reset values. `start` pulsed while busy -> ignored, single `done`.

Source files
------------

// File: rtl/mem_load_sequencer_pkg.sv
// loader_pkg: shared state encoding and default channel/RAM layout for the memory load sequencer
package loader_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, XFER, NEXT, DONE} ld_state_t;
  localparam int CH_CNN = 0;
  localparam int CH_FC = 1;
  localparam int CH_IMG = 2;
  localparam int RAM_CNN = 0;
  localparam int RAM_FC = 1;
  localparam int CNT_CNN = 50704;
  localparam int CNT_FC = 11218;
  localparam int CNT_IMG = 1024;
  localparam int IMG_BASE = 50704;
endpackage

// File: rtl/ld_chan_ctr.sv
// ld_chan_ctr: loadable write-address/remaining-word counter with last-beat and range-overflow flags
module ld_chan_ctr #(
  parameter int ADDR_W = 16,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              ovf
);
  localparam int SW = (ADDR_W > CNT_W ? ADDR_W : CNT_W) + 2;
  logic [CNT_W-1:0] remaining;
  logic [SW-1:0] end_addr;
  assign end_addr = SW'(base) + SW'(count);
  assign ovf = end_addr > (SW'(1) << ADDR_W);
  assign last = remaining == CNT_W'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      remaining <= '0;
    end else if (load) begin
      addr <= base;
      remaining <= count;
    end else if (step) begin
      addr <= addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end
endmodule

// File: rtl/mem_load_sequencer.sv
// mem_load_sequencer: streams NUM_CH channels in order into NUM_RAM memories with start/busy/done and framing checks
module mem_load_sequencer
  import loader_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int CNT_W = 16,
  parameter int NUM_CH = 3,
  parameter int NUM_RAM = 2,
  parameter int RSEL_W = (NUM_RAM > 1) ? $clog2(NUM_RAM) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_CH*CNT_W-1:0]  ch_count,
  input  logic [NUM_CH*ADDR_W-1:0] ch_base,
  input  logic [NUM_CH*RSEL_W-1:0] ch_ram,
  output logic [NUM_CH-1:0]        ch_req,
  input  logic                     s_valid,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [NUM_RAM-1:0]       ram_we,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_CH-1:0]        err
);
  localparam int CH_W = $clog2(NUM_CH + 1);
  ld_state_t state;
  logic [CH_W-1:0] ch;
  logic [NUM_CH*CNT_W-1:0] cnt_sh;
  logic [NUM_CH*ADDR_W-1:0] base_sh;
  logic [NUM_CH*RSEL_W-1:0] ram_sh;
  logic [CNT_W-1:0] cur_cnt;
  logic [ADDR_W-1:0] cur_base, addr;
  logic [RSEL_W-1:0] cur_ram;
  logic hs, last, ovf;
  assign cur_cnt = cnt_sh[ch*CNT_W +: CNT_W];
  assign cur_base = base_sh[ch*ADDR_W +: ADDR_W];
  assign cur_ram = ram_sh[ch*RSEL_W +: RSEL_W];
  assign hs = (state == XFER) && s_valid && s_ready;
  ld_chan_ctr #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_ctr (
    .clk(clk),
    .rst(rst),
    .load(state == SETUP),
    .step(hs),
    .base(cur_base),
    .count(cur_cnt),
    .addr(addr),
    .last(last),
    .ovf(ovf)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch <= '0;
      cnt_sh <= '0;
      base_sh <= '0;
      ram_sh <= '0;
      ch_req <= '0;
      s_ready <= 1'b0;
      ram_we <= '0;
      ram_addr <= '0;
      ram_wdata <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= '0;
    end else begin
      ram_we <= '0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cnt_sh <= ch_count;
          base_sh <= ch_base;
          ram_sh <= ch_ram;
          err <= '0;
          ch <= '0;
          busy <= 1'b1;
          state <= SETUP;
        end
        SETUP: if (cur_cnt == '0) begin
          state <= NEXT;
        end else if (ovf) begin
          err[ch] <= 1'b1;
          state <= NEXT;
        end else begin
          s_ready <= 1'b1;
          ch_req <= NUM_CH'(1) << ch;
          state <= XFER;
        end
        XFER: if (hs) begin
          ram_we <= NUM_RAM'(1) << cur_ram;
          ram_addr <= addr;
          ram_wdata <= s_data;
          if (last || s_last) begin
            if (last != s_last) err[ch] <= 1'b1;
            s_ready <= 1'b0;
            ch_req <= '0;
            state <= NEXT;
          end
        end
        NEXT: begin
          ch <= ch + 1'b1;
          done <= ch == CH_W'(NUM_CH - 1);
          state <= (ch == CH_W'(NUM_CH - 1)) ? DONE : SETUP;
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_load_sequencer.sv
// tb_mem_load_sequencer: directed self-checking bench for mem_load_sequencer
module tb_mem_load_sequencer;
  logic clk = 0;
  logic rst, start, s_valid, s_last, s_ready, busy, done;
  logic [47:0] ch_count, ch_base;
  logic [2:0] ch_ram, ch_req, err;
  logic [15:0] s_data, ram_addr, ram_wdata;
  logic [1:0] ram_we;
  int passed = 0, total = 0;
  int nw, done_n, done_cyc;
  bit saw010, fin;
  logic [1:0] wwe [64];
  logic [15:0] wad [64];
  logic [15:0] wdt [64];
  logic [1:0] e1w [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
  logic [15:0] e1a [9] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2, 16'd8, 16'd9};
  logic [15:0] e1d [9] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA100, 16'hA101, 16'hA102, 16'hA200, 16'hA201};

  always #5 clk = ~clk;

  mem_load_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .ch_count(ch_count), .ch_base(ch_base), .ch_ram(ch_ram),
    .ch_req(ch_req), .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"}, 32'(ch_req), 0);
    chk({tag, "_rdy"}, 32'(s_ready), 0);
    chk({tag, "_we"}, 32'(ram_we), 0);
    chk({tag, "_addr"}, 32'(ram_addr), 0);
    chk({tag, "_wdata"}, 32'(ram_wdata), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  task automatic run(input logic [47:0] cnt, input logic [47:0] base, input logic [2:0] ram,
                     input int lp0, input int lp1, input int lp2, input bit toggle, input bit restart);
    int lp [3];
    int bc [3];
    int c;
    lp[0] = lp0; lp[1] = lp1; lp[2] = lp2;
    bc[0] = 0; bc[1] = 0; bc[2] = 0;
    nw = 0; done_n = 0; done_cyc = -1; saw010 = 0; fin = 0;
    ch_count = cnt; ch_base = base; ch_ram = ram;
    start = 1;
    @(posedge clk); @(negedge clk);
    start = 0;
    ch_count = '1; ch_base = '1; ch_ram = '1;
    for (int k = 0; k < 400 && !fin; k++) begin
      if (ram_we != 0) begin
        wwe[nw] = ram_we; wad[nw] = ram_addr; wdt[nw] = ram_wdata; nw++;
      end
      if (done) begin done_n++; done_cyc = k; end
      if (ch_req == 3'b010) saw010 = 1;
      if (done_n > 0 && !done && !busy) fin = 1;
      c = ch_req[0] ? 0 : ch_req[1] ? 1 : 2;
      s_valid = !toggle || (k % 2 == 1);
      s_data = 16'hA000 + 16'(c) * 16'h100 + 16'(bc[c]);
      s_last = (bc[c] == lp[c]);
      if (s_valid && s_ready) bc[c]++;
      start = restart && (k == 5);
      @(posedge clk); @(negedge clk);
    end
    start = 0; s_valid = 0; s_last = 0;
    chk("finished", 32'(fin), 1);
  endtask

  initial begin
    rst = 1; start = 0; s_valid = 0; s_last = 0; s_data = 0;
    ch_count = 0; ch_base = 0; ch_ram = 0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk_idle_outputs("reset");
    rst = 0;

    run({16'd2, 16'd3, 16'd4}, {16'd8, 16'd0, 16'd0}, 3'b010, 3, 2, 1, 0, 0);
    chk("t1_nw", nw, 9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t1_we%0d", i), 32'(wwe[i]), 32'(e1w[i]));
      chk($sformatf("t1_addr%0d", i), 32'(wad[i]), 32'(e1a[i]));
      chk($sformatf("t1_data%0d", i), 32'(wdt[i]), 32'(e1d[i]));
    end
    chk("t1_done_n", done_n, 1);
    chk("t1_done_cyc", done_cyc, 15);
    chk("t1_err", 32'(err), 0);

    run({16'd2, 16'd0, 16'd3}, {16'd0, 16'd0, 16'd0}, 3'b110, 2, 0, 1, 0, 0);
    chk("t2_nw", nw, 5);
    chk("t2_saw010", 32'(saw010), 0);
    chk("t2_done_cyc", done_cyc, 11);
    chk("t2_w3_we", 32'(wwe[3]), 32'b10);

    run({16'd0, 16'd0, 16'd4}, {16'd0, 16'd0, 16'd0}, 3'b000, 3, 0, 0, 1, 0);
    chk("t3_nw", nw, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_addr%0d", i), 32'(wad[i]), i);
      chk($sformatf("t3_data%0d", i), 32'(wdt[i]), 32'h0000A000 + i);
    end

    run({16'd1, 16'd1, 16'd4}, {16'd30, 16'd20, 16'd0}, 3'b000, 1, 0, 0, 0, 0);
    chk("t4_err", 32'(err), 32'b001);
    chk("t4_nw", nw, 4);
    chk("t4_w1_addr", 32'(wad[1]), 1);
    chk("t4_w2_addr", 32'(wad[2]), 20);
    chk("t4_done_cyc", done_cyc, 10);

    run({16'd1, 16'd3, 16'd1}, {16'd40, 16'd0, 16'd0}, 3'b000, 0, 99, 0, 0, 0);
    chk("t5_err", 32'(err), 32'b010);
    chk("t5_nw", nw, 5);
    chk("t5_w3_addr", 32'(wad[3]), 2);

    run({16'd2, 16'd3, 16'd2}, {16'hFFFE, 16'hFFFE, 16'd0}, 3'b110, 1, 2, 1, 0, 0);
    chk("t6_err", 32'(err), 32'b010);
    chk("t6_nw", nw, 4);
    chk("t6_w2_addr", 32'(wad[2]), 32'hFFFE);
    chk("t6_w3_addr", 32'(wad[3]), 32'hFFFF);
    chk("t6_w3_we", 32'(wwe[3]), 32'b10);
    chk("t6_done_cyc", done_cyc, 10);

    run({16'd2, 16'd3, 16'd4}, {16'd8, 16'd0, 16'd0}, 3'b010, 3, 2, 1, 0, 1);
    chk("t7_done_n", done_n, 1);
    chk("t7_nw", nw, 9);
    chk("t7_err", 32'(err), 0);
    repeat (3) @(negedge clk);
    chk("t7_idle_busy", 32'(busy), 0);

    ch_count = {16'd2, 16'd3, 16'd4}; ch_base = {16'd8, 16'd5, 16'd6}; ch_ram = 3'b010;
    start = 1;
    @(posedge clk); @(negedge clk);
    start = 0; s_valid = 1; s_last = 0; s_data = 16'h5A5A;
    for (int k = 0; k < 40 && ch_req != 3'b010; k++) begin
      s_last = (ch_req == 3'b001) && ram_we == 2'b01 && ram_addr == 16'd8;
      @(posedge clk); @(negedge clk);
    end
    chk("t8_in_ch1", 32'(ch_req), 32'b010);
    rst = 1;
    @(posedge clk); @(negedge clk);
    chk_idle_outputs("t8_rst");
    rst = 0; nw = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      if (ram_we != 0 || s_ready) nw++;
    end
    chk("t8_no_writes", nw, 0);
    s_valid = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
